// File: rtl/adsr_envelope_analyzer.sv
// ADSR envelope analyzer: segments an 8-bit amplitude stream into attack, decay,
// sustain and release, and publishes peak, sustain level and phase lengths per note.
`timescale 1ns/1ps
module adsr_envelope_analyzer #(
  parameter int CNT_W      = 16,
  parameter int STABLE_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [7:0]       sample,
  output logic [2:0]       phase,
  output logic [7:0]       peak_level,
  output logic [7:0]       sustain_level,
  output logic [CNT_W-1:0] attack_len,
  output logic [CNT_W-1:0] decay_len,
  output logic [CNT_W-1:0] sustain_len,
  output logic [CNT_W-1:0] release_len,
  output logic             result_valid,
  output logic             overflow,
  output logic             retrigger
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_LEN);

  logic [2:0]       phase_q, phase_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       peak_q, peak_d;
  logic [7:0]       sus_lvl_q, sus_lvl_d;
  logic [CNT_W-1:0] att_q, att_d;
  logic [CNT_W-1:0] dec_q, dec_d;
  logic [CNT_W-1:0] sus_q, sus_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             ovf_acc_q, ovf_acc_d;

  logic [7:0]       peak_level_q, peak_level_d;
  logic [7:0]       sustain_level_q, sustain_level_d;
  logic [CNT_W-1:0] attack_len_q, attack_len_d;
  logic [CNT_W-1:0] decay_len_q, decay_len_d;
  logic [CNT_W-1:0] sustain_len_q, sustain_len_d;
  logic [CNT_W-1:0] release_len_q, release_len_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic             retrigger_q, retrigger_d;

  logic             start_note;
  logic             end_note;
  logic [CNT_W-1:0] dec_inc;
  logic [CNT_W-1:0] run_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  // Pulses default low so they last exactly one cycle even when no sample arrives.
  always_comb begin
    phase_d         = phase_q;
    prev_d          = prev_q;
    peak_d          = peak_q;
    sus_lvl_d       = sus_lvl_q;
    att_d           = att_q;
    dec_d           = dec_q;
    sus_d           = sus_q;
    rel_d           = rel_q;
    run_d           = run_q;
    ovf_acc_d       = ovf_acc_q;
    peak_level_d    = peak_level_q;
    sustain_level_d = sustain_level_q;
    attack_len_d    = attack_len_q;
    decay_len_d     = decay_len_q;
    sustain_len_d   = sustain_len_q;
    release_len_d   = release_len_q;
    overflow_d      = overflow_q;
    result_valid_d  = 1'b0;
    retrigger_d     = 1'b0;
    start_note      = 1'b0;
    end_note        = 1'b0;
    dec_inc         = sat_inc(dec_q);
    run_inc         = run_q + ONE;

    if (sample_valid) begin
      prev_d = sample;
      if (phase_q == S_IDLE) begin
        start_note = (sample != 8'd0);
      end else if (sample == 8'd0) begin
        end_note = 1'b1;
      end else begin
        case (phase_q)
          S_ATTACK: begin
            if (sample >= prev_q) begin
              att_d     = sat_inc(att_q);
              ovf_acc_d = ovf_acc_q | (att_q == CNT_MAX);
              if (sample > peak_q) peak_d = sample;
            end else begin
              phase_d = S_DECAY;
              dec_d   = ONE;
              run_d   = ONE;
            end
          end
          S_DECAY: begin
            if (sample < prev_q) begin
              dec_d     = dec_inc;
              run_d     = ONE;
              ovf_acc_d = ovf_acc_q | (dec_q == CNT_MAX);
            end else if (sample == prev_q) begin
              ovf_acc_d = ovf_acc_q | (dec_q == CNT_MAX);
              // The equal run was counted as decay; hand it over to sustain.
              if (run_inc == STABLE_C) begin
                phase_d   = S_SUSTAIN;
                sus_lvl_d = sample;
                dec_d     = dec_inc - STABLE_C;
                sus_d     = STABLE_C;
                run_d     = '0;
              end else begin
                dec_d = dec_inc;
                run_d = run_inc;
              end
            end else begin
              start_note  = 1'b1;
              retrigger_d = 1'b1;
            end
          end
          S_SUSTAIN: begin
            if (sample == sus_lvl_q) begin
              sus_d     = sat_inc(sus_q);
              ovf_acc_d = ovf_acc_q | (sus_q == CNT_MAX);
            end else if (sample < sus_lvl_q) begin
              phase_d = S_RELEASE;
              rel_d   = ONE;
            end else begin
              start_note  = 1'b1;
              retrigger_d = 1'b1;
            end
          end
          S_RELEASE: begin
            if (sample <= prev_q) begin
              rel_d     = sat_inc(rel_q);
              ovf_acc_d = ovf_acc_q | (rel_q == CNT_MAX);
            end else begin
              start_note  = 1'b1;
              retrigger_d = 1'b1;
            end
          end
          default: phase_d = S_IDLE;
        endcase
      end
    end

    if (start_note) begin
      phase_d   = S_ATTACK;
      peak_d    = sample;
      sus_lvl_d = '0;
      att_d     = ONE;
      dec_d     = '0;
      sus_d     = '0;
      rel_d     = '0;
      run_d     = '0;
      ovf_acc_d = 1'b0;
    end

    // Phases not reached by this note still hold zero from note start.
    if (end_note) begin
      peak_level_d    = peak_q;
      sustain_level_d = sus_lvl_q;
      attack_len_d    = att_q;
      decay_len_d     = dec_q;
      sustain_len_d   = sus_q;
      release_len_d   = rel_q;
      overflow_d      = ovf_acc_q;
      result_valid_d  = 1'b1;
      phase_d         = S_IDLE;
      peak_d          = '0;
      sus_lvl_d       = '0;
      att_d           = '0;
      dec_d           = '0;
      sus_d           = '0;
      rel_d           = '0;
      run_d           = '0;
      ovf_acc_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q         <= S_IDLE;
      prev_q          <= '0;
      peak_q          <= '0;
      sus_lvl_q       <= '0;
      att_q           <= '0;
      dec_q           <= '0;
      sus_q           <= '0;
      rel_q           <= '0;
      run_q           <= '0;
      ovf_acc_q       <= 1'b0;
      peak_level_q    <= '0;
      sustain_level_q <= '0;
      attack_len_q    <= '0;
      decay_len_q     <= '0;
      sustain_len_q   <= '0;
      release_len_q   <= '0;
      result_valid_q  <= 1'b0;
      overflow_q      <= 1'b0;
      retrigger_q     <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      prev_q          <= prev_d;
      peak_q          <= peak_d;
      sus_lvl_q       <= sus_lvl_d;
      att_q           <= att_d;
      dec_q           <= dec_d;
      sus_q           <= sus_d;
      rel_q           <= rel_d;
      run_q           <= run_d;
      ovf_acc_q       <= ovf_acc_d;
      peak_level_q    <= peak_level_d;
      sustain_level_q <= sustain_level_d;
      attack_len_q    <= attack_len_d;
      decay_len_q     <= decay_len_d;
      sustain_len_q   <= sustain_len_d;
      release_len_q   <= release_len_d;
      result_valid_q  <= result_valid_d;
      overflow_q      <= overflow_d;
      retrigger_q     <= retrigger_d;
    end
  end

  assign phase         = phase_q;
  assign peak_level    = peak_level_q;
  assign sustain_level = sustain_level_q;
  assign attack_len    = attack_len_q;
  assign decay_len     = decay_len_q;
  assign sustain_len   = sustain_len_q;
  assign release_len   = release_len_q;
  assign result_valid  = result_valid_q;
  assign overflow      = overflow_q;
  assign retrigger     = retrigger_q;

endmodule

// File: tb/tb_adsr_envelope_analyzer.sv
// Scoreboard bench for adsr_envelope_analyzer: a 16-bit and a 4-bit counter instance
// share one stimulus stream and are checked against a phase-rule reference model.
`timescale 1ns/1ps
module tb_adsr_envelope_analyzer;

  localparam int STABLE_LEN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample;

  logic [2:0]  phase_a, phase_b;
  logic [7:0]  peak_a, peak_b, slvl_a, slvl_b;
  logic [15:0] att_a, dec_a, sus_a, rel_a;
  logic [3:0]  att_b, dec_b, sus_b, rel_b;
  logic        rv_a, rv_b, ovf_a, ovf_b, rt_a, rt_b;

  always #5 clk = ~clk;

  adsr_envelope_analyzer #(.CNT_W(16), .STABLE_LEN(STABLE_LEN)) dut_a (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .phase(phase_a), .peak_level(peak_a), .sustain_level(slvl_a),
    .attack_len(att_a), .decay_len(dec_a), .sustain_len(sus_a), .release_len(rel_a),
    .result_valid(rv_a), .overflow(ovf_a), .retrigger(rt_a)
  );

  adsr_envelope_analyzer #(.CNT_W(4), .STABLE_LEN(STABLE_LEN)) dut_b (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .phase(phase_b), .peak_level(peak_b), .sustain_level(slvl_b),
    .attack_len(att_b), .decay_len(dec_b), .sustain_len(sus_b), .release_len(rel_b),
    .result_valid(rv_b), .overflow(ovf_b), .retrigger(rt_b)
  );

  typedef struct {
    bit is_retrig;
    int peak;
    int slvl;
    int att;
    int dec;
    int sus;
    int rel;
    bit ovf;
  } note_ev_t;

  note_ev_t q_a[$];
  note_ev_t q_b[$];
  int vectors = 0;
  int miscompares = 0;

  int max_cnt[2] = '{65535, 15};
  int m_phase, m_prev, m_peak, m_slvl, m_run;
  int m_cnt[4][2];
  bit m_ovf[2];

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: phase index 0..4, counters k = 0 attack, 1 decay, 2 sustain, 3 release.
  task automatic model_clear();
    m_phase = 0; m_peak = 0; m_slvl = 0; m_run = 0;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 2; w++) m_cnt[k][w] = 0;
    m_ovf[0] = 0; m_ovf[1] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_prev = 0;
  endtask

  task automatic bump(input int k);
    for (int w = 0; w < 2; w++) begin
      if (m_cnt[k][w] >= max_cnt[w]) m_ovf[w] = 1;
      else m_cnt[k][w] = m_cnt[k][w] + 1;
    end
  endtask

  task automatic push_ev(input bit retrig);
    note_ev_t e;
    for (int w = 0; w < 2; w++) begin
      e.is_retrig = retrig;
      e.peak = m_peak;
      e.att  = m_cnt[0][w];
      e.dec  = (m_phase == 1) ? 0 : m_cnt[1][w];
      e.slvl = (m_phase >= 3) ? m_slvl : 0;
      e.sus  = (m_phase >= 3) ? m_cnt[2][w] : 0;
      e.rel  = (m_phase == 4) ? m_cnt[3][w] : 0;
      e.ovf  = m_ovf[w];
      if (w == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
  endtask

  task automatic model_start(input int s);
    model_clear();
    m_phase = 1;
    m_peak  = s;
    m_cnt[0][0] = 1;
    m_cnt[0][1] = 1;
  endtask

  task automatic model_step(input int s);
    if (m_phase == 0) begin
      if (s != 0) model_start(s);
    end else if (s == 0) begin
      push_ev(1'b0);
      model_clear();
    end else begin
      case (m_phase)
        1: begin
          if (s >= m_prev) begin
            bump(0);
            if (s > m_peak) m_peak = s;
          end else begin
            m_phase = 2; m_run = 1;
            m_cnt[1][0] = 1; m_cnt[1][1] = 1;
          end
        end
        2: begin
          if (s < m_prev) begin
            bump(1); m_run = 1;
          end else if (s == m_prev) begin
            bump(1); m_run++;
            if (m_run == STABLE_LEN) begin
              m_phase = 3; m_slvl = s;
              for (int w = 0; w < 2; w++) begin
                m_cnt[1][w] = m_cnt[1][w] - STABLE_LEN;
                m_cnt[2][w] = STABLE_LEN;
              end
            end
          end else begin
            push_ev(1'b1); model_start(s);
          end
        end
        3: begin
          if (s == m_slvl) bump(2);
          else if (s < m_slvl) begin
            m_phase = 4; m_cnt[3][0] = 1; m_cnt[3][1] = 1;
          end else begin
            push_ev(1'b1); model_start(s);
          end
        end
        4: begin
          if (s <= m_prev) bump(3);
          else begin
            push_ev(1'b1); model_start(s);
          end
        end
        default: ;
      endcase
    end
    m_prev = s;
  endtask

  task automatic checkOutput(input int w, input bit rv, input bit rt, input int pk, input int sl,
                             input int at, input int de, input int su, input int re, input bit ov);
    note_ev_t e;
    string tag;
    tag = (w == 0) ? "w16" : "w4";
    if (!(rv || rt)) return;
    if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s unexpected_event: result_valid=%0b retrigger=%0b, required none", tag, rv, rt);
      return;
    end
    e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
    cmp({tag, " retrigger"}, int'(rt), int'(e.is_retrig));
    cmp({tag, " result_valid"}, int'(rv), int'(!e.is_retrig));
    if (rv && !e.is_retrig) begin
      cmp({tag, " peak_level"}, pk, e.peak);
      cmp({tag, " sustain_level"}, sl, e.slvl);
      cmp({tag, " attack_len"}, at, e.att);
      cmp({tag, " decay_len"}, de, e.dec);
      cmp({tag, " sustain_len"}, su, e.sus);
      cmp({tag, " release_len"}, re, e.rel);
      cmp({tag, " overflow"}, int'(ov), int'(e.ovf));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput(0, rv_a, rt_a, int'(peak_a), int'(slvl_a), int'(att_a), int'(dec_a),
                  int'(sus_a), int'(rel_a), ovf_a);
      checkOutput(1, rv_b, rt_b, int'(peak_b), int'(slvl_b), int'(att_b), int'(dec_b),
                  int'(sus_b), int'(rel_b), ovf_b);
    end
  end

  // Inputs change 1 time unit after a rising edge; phase is compared after the next one.
  task automatic applyStimulus(input bit v, input int s);
    sample_valid = v;
    sample       = 8'(s);
    if (v) model_step(s);
    @(posedge clk);
    #1;
    cmp("phase_w16", int'(phase_a), m_phase);
    cmp("phase_w4", int'(phase_b), m_phase);
  endtask

  task automatic play(input int seq[$], input int gap_pct);
    foreach (seq[i]) begin
      if ($urandom_range(99) < gap_pct) applyStimulus(1'b0, int'($urandom_range(255)));
      applyStimulus(1'b1, seq[i]);
    end
  endtask

  task automatic drain();
    repeat (3) applyStimulus(1'b0, 0);
    cmp("pending_w16", q_a.size(), 0);
    cmp("pending_w4", q_b.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, " phase"}, int'(phase_a) + int'(phase_b), 0);
    cmp({tag, " levels"}, int'(peak_a) + int'(slvl_a) + int'(peak_b) + int'(slvl_b), 0);
    cmp({tag, " lens_w16"}, int'(att_a) + int'(dec_a) + int'(sus_a) + int'(rel_a), 0);
    cmp({tag, " lens_w4"}, int'(att_b) + int'(dec_b) + int'(sus_b) + int'(rel_b), 0);
    cmp({tag, " flags"}, int'(rv_a) + int'(ovf_a) + int'(rt_a) + int'(rv_b) + int'(ovf_b) + int'(rt_b), 0);
  endtask

  task automatic check_test1(input string tag);
    cmp({tag, " peak"}, int'(peak_a), 4);
    cmp({tag, " sustain_level"}, int'(slvl_a), 2);
    cmp({tag, " attack_len"}, int'(att_a), 5);
    cmp({tag, " decay_len"}, int'(dec_a), 1);
    cmp({tag, " sustain_len"}, int'(sus_a), 6);
    cmp({tag, " release_len"}, int'(rel_a), 1);
    cmp({tag, " overflow"}, int'(ovf_a), 0);
  endtask

  task automatic random_note();
    int seq[$];
    int lvl;
    lvl = int'($urandom_range(1, 20));
    seq.push_back(lvl);
    repeat ($urandom_range(0, 21)) begin
      lvl = lvl + int'($urandom_range(0, 12));
      if (lvl > 255) lvl = 255;
      seq.push_back(lvl);
    end
    repeat ($urandom_range(0, 8)) begin
      lvl = lvl - int'($urandom_range(0, 3));
      if (lvl < 1) lvl = 1;
      seq.push_back(lvl);
    end
    repeat ($urandom_range(0, 22)) seq.push_back(lvl);
    repeat ($urandom_range(0, 20)) begin
      lvl = lvl - int'($urandom_range(0, 2));
      if (lvl < 1) lvl = 1;
      seq.push_back(lvl);
    end
    if ($urandom_range(3) == 0) begin
      lvl = lvl + int'($urandom_range(1, 9));
      if (lvl > 255) lvl = 255;
      seq.push_back(lvl);
    end
    seq.push_back(0);
    play(seq, 25);
  endtask

  initial begin
    int seq[$];
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("reset");

    $display("[TB] directed: full ADSR note");
    seq = '{0, 1, 2, 3, 4, 4, 3, 2, 2, 2, 2, 2, 2, 1, 0};
    play(seq, 0);
    drain();
    check_test1("t1");

    $display("[TB] directed: same note with idle cycles between samples");
    play(seq, 100);
    drain();
    check_test1("t2");

    $display("[TB] directed: note ending in decay");
    seq = '{0, 5, 10, 6, 3, 0};
    play(seq, 0);
    drain();
    cmp("t3 peak", int'(peak_a), 10);
    cmp("t3 attack_len", int'(att_a), 2);
    cmp("t3 decay_len", int'(dec_a), 2);
    cmp("t3 sustain", int'(slvl_a) + int'(sus_a) + int'(rel_a), 0);

    $display("[TB] directed: retrigger out of sustain");
    seq = '{1, 2, 3, 2, 2, 2, 2, 2, 7, 0};
    play(seq, 0);
    drain();
    cmp("t4 peak", int'(peak_a), 7);
    cmp("t4 attack_len", int'(att_a), 1);
    cmp("t4 others", int'(dec_a) + int'(slvl_a) + int'(sus_a) + int'(rel_a), 0);

    $display("[TB] directed: long attack saturating narrow counters");
    seq.delete();
    for (int i = 1; i <= 20; i++) seq.push_back(i);
    seq.push_back(0);
    play(seq, 0);
    drain();
    cmp("t5 attack_len_w4", int'(att_b), 15);
    cmp("t5 overflow_w4", int'(ovf_b), 1);
    cmp("t5 peak_w4", int'(peak_b), 20);
    cmp("t5 attack_len_w16", int'(att_a), 20);
    cmp("t5 overflow_w16", int'(ovf_a), 0);

    $display("[TB] directed: asynchronous reset during sustain");
    seq = '{0, 1, 3, 5, 5, 4, 4, 4, 4, 4};
    play(seq, 0);
    cmp("t6 in_sustain", int'(phase_a), 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_zero("t6 reset");
    cmp("t6 pending", q_a.size() + q_b.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seq = '{0, 1, 2, 3, 4, 4, 3, 2, 2, 2, 2, 2, 2, 1, 0};
    play(seq, 0);
    drain();
    check_test1("t6 after");

    $display("[TB] random shaped notes");
    repeat (40) random_note();
    drain();

    $display("[TB] random small-alphabet stream");
    repeat (400) applyStimulus($urandom_range(3) != 0, int'($urandom_range(0, 6)));
    applyStimulus(1'b1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adsr_envelope_analyzer.md
Name: adsr_envelope_analyzer

Overview:
- Measures the ADSR envelope of an incoming 8-bit amplitude or rectified-wave sample stream, e.g. the envelope generator's amplitude output or an external capture.
- Segments each note into attack, decay, sustain and release, and reports per note: peak level, sustain level and the length of each phase in samples.
- Sits on the analysis/visualisation side of the signal generator as its measurement counterpart.

Parameters:
- CNT_W, 16, width of the phase-length counters and outputs.
- STABLE_LEN, 4, number of consecutive equal samples (≥2) during decay that declares sustain.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sample_valid  input  1  qualifies sample; only valid samples are processed or counted
- sample  input  8  unsigned amplitude sample
- phase  output  3  current state: 0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
- peak_level  output  8  max sample of last completed note
- sustain_level  output  8  sustain level of last completed note (0 if none)
- attack_len  output  CNT_W  samples in attack
- decay_len  output  CNT_W  samples in decay
- sustain_len  output  CNT_W  samples in sustain
- release_len  output  CNT_W  samples in release
- result_valid  output  1  one-cycle pulse when a completed note's results are updated
- overflow  output  1  a phase counter saturated during the last completed note
- retrigger  output  1  one-cycle pulse when a note is aborted by a rising sample

Behaviour:
- Reset: all outputs 0, phase=IDLE, prev sample=0, all internal counters 0. Reset mid-note discards the note.
- All state is updated only on clk edges with sample_valid=1; otherwise everything holds. "prev" is the last valid sample.
- Terminating sample is sample==0 in any active phase.
  - On it, the result registers load in the same edge, result_valid pulses high for that one cycle after the edge, and phase returns to IDLE.
  - The terminating zero is not counted in any phase.
- Result outputs hold their values until the next completed note.
- IDLE:
  - sample>0 -> ATTACK; attack count=1, peak=sample.
  - sample==0 stays.
- ATTACK:
  - sample>=prev: count++, peak=max(peak,sample).
  - 0<sample<prev -> DECAY; decay count=1, equal-run=1.
- DECAY:
  - sample<prev (nonzero): count++, run=1.
  - sample==prev: count++, run++.
    - When run reaches STABLE_LEN -> SUSTAIN.
    - sustain_level=sample; decay count -= STABLE_LEN; sustain count=STABLE_LEN.
  - sample>prev: retrigger.
- SUSTAIN:
  - sample==sustain_level: count++.
  - 0<sample<sustain_level -> RELEASE; release count=1.
  - sample>sustain_level: retrigger.
- RELEASE:
  - 0<sample<=prev: count++.
  - sample>prev: retrigger.
- Retrigger:
  - Pulse retrigger for one cycle; result outputs unchanged.
  - Go to ATTACK with attack count=1, peak=sample, other counts 0, overflow-accumulator cleared.
- Note ending in ATTACK or DECAY:
  - sustain_level=0, sustain_len=0, release_len=0.
  - decay_len=0 if ended in ATTACK.
- Counters saturate at 2^CNT_W-1, never wrap; saturation sets the note's overflow bit, latched into overflow at completion.
- STABLE_LEN subtraction never underflows: run ≤ count by construction.
- Latency: result outputs valid the cycle after the edge that accepted the terminating zero.
- phase reflects the state after the current edge.

Test Plan:
- Reset then stream 0,1,2,3,4,4,3,2,2,2,2,2,2,1,0 -> result_valid once after final 0; peak=4, sustain_level=2, attack_len=5, decay_len=1, sustain_len=6, release_len=1, overflow=0.
- Same stream with sample_valid low on alternate cycles (repeated garbage data on invalid cycles) -> identical results; phase holds on invalid cycles.
- Stream 0,5,10,6,3,0 -> peak=10, attack_len=2, decay_len=2, sustain_level=0, sustain_len=0, release_len=0.
- Stream 1,2,3,2,2,2,2,2,7,0 -> retrigger pulse at sample 7, no result for first note; then result attack_len=1, peak=7, decay_len=0, others 0.
- CNT_W=4, attack rising 1..20 then 0 -> attack_len=15, overflow=1, peak=20.
- Assert reset mid-SUSTAIN -> all outputs 0, phase=IDLE immediately (asynchronous); next full note is measured correctly from scratch.
